// File: rtl/burst_stream_tx_pkg.sv
// Shared constants and FSM encoding for the burst transmit block.
package burst_stream_tx_pkg;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ADDR_W  = 12;
  localparam int DEF_DEPTH   = 4096;
  localparam int DEF_MIN_GAP = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREFETCH = 2'd1,
    ST_SEND     = 2'd2,
    ST_GAP      = 2'd3
  } state_t;
endpackage

// File: rtl/burst_stream_tx_if.sv
// Host load / start path and the valid-framed output stream of burst_stream_tx.
interface burst_stream_tx_if
  import burst_stream_tx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  // Load: a word is taken on a rising edge where ld_valid && ld_ready.
  // Stream: out_valid frames a contiguous burst with no backpressure;
  // out_data is zero whenever out_valid is low.
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              start;
  logic [ADDR_W:0]   burst_len;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   ld_count;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  modport master (
    output ld_valid, ld_data, start, burst_len,
    input  ld_ready, busy, done, ld_count, out_valid, out_data
  );

  modport slave (
    input  ld_valid, ld_data, start, burst_len,
    output ld_ready, busy, done, ld_count, out_valid, out_data
  );
endinterface

// File: rtl/burst_stream_buf.sv
// Single-port synchronous RAM, read-first, one-cycle read latency.
module burst_stream_buf #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] DI,
  output logic [DATA_W-1:0] DO,
  input  logic              WE_B
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!WE_B) mem[A] <= DI;
    DO <= mem[A];
  end
endmodule

// File: rtl/burst_stream_tx.sv
// Buffers host-loaded words and replays them as one contiguous valid-framed burst.
module burst_stream_tx
  import burst_stream_tx_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int MIN_GAP = DEF_MIN_GAP
) (
  input  logic               clk,
  input  logic               rst_n,
  burst_stream_tx_if.slave   bus,
  output state_t             state
);
  localparam int              GAP_W     = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [ADDR_W:0] FULL      = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(MIN_GAP - 1);

  logic [ADDR_W:0]   ld_count;
  logic [ADDR_W:0]   n_words;
  logic [ADDR_W:0]   sent;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] ram_addr;
  logic [GAP_W-1:0]  gap_cnt;
  logic [DATA_W-1:0] ram_dout;
  logic              start_ok;
  logic              load_ok;
  logic              busy_q;
  logic              done_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;

  function automatic logic [ADDR_W-1:0] step(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? a : a + 1'b1;
  endfunction

  assign start_ok = (state == ST_IDLE) && bus.start && (ld_count != '0);
  assign load_ok  = (state == ST_IDLE) && bus.ld_valid && (ld_count != FULL) && !start_ok;

  assign bus.ld_ready  = (state == ST_IDLE) && (ld_count != FULL);
  assign bus.ld_count  = ld_count;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  // Word 0 is read on the accepting edge so it sits in the RAM output
  // register during PREFETCH and can be registered out on the next edge.
  always_comb begin
    ram_addr = rd_addr;
    if (state == ST_IDLE) ram_addr = start_ok ? '0 : ld_count[ADDR_W-1:0];
  end

  burst_stream_buf #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk (clk),
    .A   (ram_addr),
    .DI  (bus.ld_data),
    .DO  (ram_dout),
    .WE_B(!load_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ld_count    <= '0;
      n_words     <= '0;
      sent        <= '0;
      rd_addr     <= '0;
      gap_cnt     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state   <= ST_PREFETCH;
            busy_q  <= 1'b1;
            n_words <= (bus.burst_len == '0 || bus.burst_len > ld_count) ? ld_count : bus.burst_len;
            rd_addr <= step('0);
          end else if (load_ok) begin
            ld_count <= ld_count + 1'b1;
          end
        end
        ST_PREFETCH: begin
          state       <= ST_SEND;
          out_valid_q <= 1'b1;
          out_data_q  <= ram_dout;
          sent        <= (ADDR_W+1)'(1);
          rd_addr     <= step(rd_addr);
        end
        ST_SEND: begin
          if (sent == n_words) begin
            state       <= ST_GAP;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            gap_cnt     <= '0;
            done_q      <= (MIN_GAP == 1);
          end else begin
            out_data_q <= ram_dout;
            sent       <= sent + 1'b1;
            rd_addr    <= step(rd_addr);
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state    <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ld_count <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
            done_q  <= (GAP_W'(gap_cnt + 1'b1) == GAP_LAST);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_burst_stream_tx.sv
// Scoreboard bench for burst_stream_tx: directed and random bursts against a buffer model.
module tb_burst_stream_tx;
  import burst_stream_tx_pkg::*;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 12;
  localparam int DEPTH   = 4096;
  localparam int MIN_GAP = 2;

  logic   clk = 1'b0;
  logic   rst_n;
  state_t dut_state;
  int     cyc = 0;

  burst_stream_tx_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  burst_stream_tx #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .MIN_GAP(MIN_GAP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .state(dut_state)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Model and scoreboard
  logic [DATA_W-1:0] model_mem [DEPTH];
  int                model_count;
  logic [DATA_W-1:0] exp_q[$];
  int                checks = 0;
  int                errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expected word per out_valid cycle, tracks burst framing
  int first_v = -1;
  int last_v  = -1;
  int run_len = 0;
  bit prev_v  = 1'b0;

  always @(negedge clk) begin
    logic [DATA_W-1:0] w;
    if (bus.out_valid) begin
      if (!prev_v) begin
        first_v = cyc;
        run_len = 0;
      end
      run_len++;
      last_v = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 32'(bus.out_data), 32'hffff_ffff);
      end else begin
        w = exp_q.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(w));
      end
    end else begin
      chk("out_data_idle_zero", 32'(bus.out_data), 0);
    end
    prev_v = bus.out_valid;
  end

  // Driver tasks
  task automatic load_word(input logic [DATA_W-1:0] d);
    bit acc;
    acc = (model_count < DEPTH);
    chk("ld_count", 32'(bus.ld_count), model_count);
    chk("ld_ready", 32'(bus.ld_ready), 32'(acc));
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    @(posedge clk); #1;
    bus.ld_valid = 1'b0;
    if (acc) begin
      model_mem[model_count] = d;
      model_count++;
    end
  endtask

  task automatic do_start(input int len, input bit hold, output int c0, output int n);
    n  = (len == 0 || len > model_count) ? model_count : len;
    c0 = cyc;
    bus.start     = 1'b1;
    bus.burst_len = (ADDR_W+1)'(len);
    for (int i = 0; i < n; i++) exp_q.push_back(model_mem[i]);
    @(posedge clk); #1;
    if (!hold) bus.start = 1'b0;
    bus.burst_len = (ADDR_W+1)'($urandom);
    chk("busy_after_start", 32'(bus.busy), 1);
    chk("prefetch_state", 32'(dut_state), 32'(ST_PREFETCH));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_state"}, 32'(dut_state), 32'(ST_IDLE));
    chk({tag, "_ld_ready"}, 32'(bus.ld_ready), 1);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_ld_count"}, 32'(bus.ld_count), 0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
  endtask

  task automatic wait_done(input int c0, input int n);
    int got;
    got = -1;
    for (int k = 0; k < n + MIN_GAP + 20; k++) begin
      @(negedge clk);
      if (bus.done) begin
        got = cyc;
        break;
      end
    end
    chk("done_cycle", got, c0 + n + MIN_GAP + 1);
    chk("first_valid_cycle", first_v, c0 + 2);
    chk("burst_length", run_len, n);
    @(posedge clk); #1;
    check_idle("post_done");
    model_count = 0;
  endtask

  // Stimulus
  initial begin
    int c0, n, c1, last1, nw, len;
    rst_n         = 1'b0;
    bus.ld_valid  = 1'b0;
    bus.ld_data   = '0;
    bus.start     = 1'b0;
    bus.burst_len = '0;
    model_count   = 0;

    repeat (3) @(negedge clk);
    check_idle("reset");
    chk("reset_out_data", 32'(bus.out_data), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("after_reset");

    // start with nothing loaded is ignored
    bus.start = 1'b1;
    bus.burst_len = 5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) begin
      chk("empty_start_busy", 32'(bus.busy), 0);
      chk("empty_start_state", 32'(dut_state), 32'(ST_IDLE));
      @(posedge clk); #1;
    end

    // four known words, send all
    load_word(16'h0011);
    load_word(16'h0022);
    load_word(16'h0033);
    load_word(16'h0044);
    do_start(0, 1'b0, c0, n);
    wait_done(c0, n);

    // partial burst, then clamped burst
    for (int i = 0; i < 8; i++) load_word(16'($urandom));
    do_start(3, 1'b0, c0, n);
    wait_done(c0, n);
    for (int i = 0; i < 8; i++) load_word(16'($urandom));
    do_start(20, 1'b0, c0, n);
    wait_done(c0, n);

    // random bursts with start and load pulses injected while busy
    for (int r = 0; r < 6; r++) begin
      nw  = $urandom_range(1, 40);
      len = $urandom_range(0, 50);
      for (int i = 0; i < nw; i++) load_word(16'($urandom));
      do_start(len, 1'b0, c0, n);
      chk("ld_ready_while_busy", 32'(bus.ld_ready), 0);
      bus.start     = 1'b1;
      bus.ld_valid  = 1'b1;
      bus.ld_data   = 16'hdead;
      bus.burst_len = 1;
      @(posedge clk); #1;
      bus.start    = 1'b0;
      bus.ld_valid = 1'b0;
      wait_done(c0, n);
    end

    // reset during word 2 of a 6-word burst
    for (int i = 0; i < 6; i++) load_word(16'($urandom));
    do_start(0, 1'b0, c0, n);
    while (cyc < c0 + 4) begin
      @(posedge clk); #1;
    end
    chk("mid_burst_valid", 32'(bus.out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(bus.out_valid), 0);
    chk("async_rst_out_data", 32'(bus.out_data), 0);
    chk("async_rst_busy", 32'(bus.busy), 0);
    exp_q.delete();
    model_count = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("after_mid_reset");

    // start held high across two bursts
    for (int i = 0; i < 3; i++) load_word(16'($urandom));
    do_start(0, 1'b1, c0, n);
    wait_done(c0, n);
    last1 = last_v;
    load_word(16'($urandom));
    c1 = cyc;
    exp_q.push_back(model_mem[0]);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(c1, 1);
    chk("b2b_gap", 32'((first_v - last1) >= MIN_GAP + 1), 1);

    // fill the whole buffer, one extra load, full-depth burst
    for (int i = 0; i < DEPTH; i++) load_word(16'($urandom));
    chk("full_ld_ready", 32'(bus.ld_ready), 0);
    chk("full_ld_count", 32'(bus.ld_count), DEPTH);
    load_word(16'h5a5a);
    chk("full_ld_count_after_extra", 32'(bus.ld_count), DEPTH);
    do_start(0, 1'b0, c0, n);
    wait_done(c0, n);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
